// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle MIPS multiply/divide unit that owns the HI/LO registers.
//   Handles mult, multu, div, divu (iterative radix-2: shift-add multiply,
//   restoring divide) and the mthi/mtlo register writes.
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   launch an operation (only sampled while idle)
//   op      00 multu, 01 mult, 10 divu, 11 div
//   rs_val  multiplicand / dividend
//   rt_val  multiplier / divisor
//   mthi    write wdata to HI (idle, no start)
//   mtlo    write wdata to LO (idle, no start)
//   wdata   data for mthi/mtlo
//   busy    high while an operation is in flight (RUN, FIX)
//   done    registered one-cycle pulse; hi/lo already hold the result
//   hi, lo  architectural HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    counter;
  logic             is_div;
  logic             div_zero;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] rs_latch;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Signed ops work on magnitudes; the sign is reapplied in FIX.
  // The most negative value maps onto itself, which is correct as unsigned.
  assign rs_neg = op[0] & rs_val[WIDTH-1];
  assign rt_neg = op[0] & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // Multiply step: work_hi accumulates, work_lo holds the remaining multiplier
  // bits and collects product bits shifted out of the accumulator.
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_reg} : '0);

  // Restoring divide step: work_hi is the partial remainder, work_lo shifts the
  // dividend out at the top and the quotient bits in at the bottom.
  assign div_shift = {work_hi, work_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_ok    = ~div_diff[WIDTH];

  assign prod     = {work_hi, work_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -work_lo : work_lo;
  assign rem_fix  = neg_r ? -work_hi : work_hi;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and busy: RUN spends exactly WIDTH edges, FIX one edge.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (counter == LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign fix-up and HI/LO writes.
  // HI/LO are only touched by mthi/mtlo in IDLE or by the FIX write, so an
  // aborted operation never leaves a partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_reg    <= '0;
      rs_latch <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            counter  <= '0;
            is_div   <= op[1];
            div_zero <= op[1] & (rt_val == '0);
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            rs_latch <= rs_val;
            work_hi  <= '0;
            if (op[1]) begin
              work_lo <= rs_mag;
              b_reg   <= rt_mag;
            end else begin
              work_lo <= rt_mag;
              b_reg   <= rs_mag;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          counter <= counter + CW'(1);
          if (is_div) begin
            work_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], div_ok};
          end else begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (div_zero) begin
            lo <= '1;
            hi <= rs_latch;
          end else if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. Each launched operation pushes its
//   expected {hi,lo} onto a scoreboard queue; a monitor pops and compares on
//   every done pulse. Scenario tasks check latency, busy, and HI/LO side rules.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run;
  int tests_failed;
  logic [63:0] exp_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written directly from MIPS semantics.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (o)
      2'b00: r = {32'b0, a} * {32'b0, b};
      2'b01: begin p = sa * sb; r = p; end
      2'b10: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle and records what the result should be.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    exp_q.push_back(expv);
    tick();
    start  = 1'b0;
    op     = 2'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Counts edges until done is seen (bounded) and how many samples had busy=1.
  task automatic waitDone(output int cycles, output int busy_cnt);
    cycles = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cycles++;
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_done got hi=%h lo=%h, no result expected", hi, lo);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          tests_failed++;
          $display("[TB] FAIL result got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #3;
    tests_run++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int c, b;
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    waitDone(c, b);
    tests_run++;
    if (c !== 33 || b !== 33) begin
      tests_failed++;
      $display("[TB] FAIL multu_latency got done_after=%0d busy_cycles=%0d expected 33/33", c, b);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_pulse got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_signed();
    int c, b;
    logic [31:0] hold_hi, hold_lo;
    applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    hold_hi = hi; hold_lo = lo;
    repeat (5) tick();
    tests_run++;
    if (hi !== hold_hi || lo !== hold_lo) begin
      tests_failed++;
      $display("[TB] FAIL hilo_hold_in_run got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, hold_hi, hold_lo);
    end
    waitDone(c, b);
    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    waitDone(c, b);
    applyStimulus(2'b10, 32'd100, 32'd7, {32'd2, 32'd14});
    waitDone(c, b);
    tests_run++;
    if (c !== 33) begin
      tests_failed++;
      $display("[TB] FAIL divu_latency got %0d expected 33", c);
    end
  endtask

  task automatic test_div_edge();
    int c, b;
    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    waitDone(c, b);
    applyStimulus(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    waitDone(c, b);
    tests_run++;
    if (c !== 33 || b !== 33) begin
      tests_failed++;
      $display("[TB] FAIL div_zero_latency got done_after=%0d busy_cycles=%0d expected 33/33", c, b);
    end
    applyStimulus(2'b11, 32'hFFFFFFF6, 32'd0, {32'hFFFFFFF6, 32'hFFFFFFFF});
    waitDone(c, b);
  endtask

  task automatic test_back_to_back();
    int c, b;
    applyStimulus(2'b00, 32'd1000, 32'd3000, 64'd3000000);
    tick();
    start = 1'b1; op = 2'b11; rs_val = 32'd77; rt_val = 32'd1;
    tick();
    start = 1'b0; mthi = 1'b1; wdata = 32'hDEAD;
    tick();
    mthi = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(c, b);
    tests_run++;
    if (c !== 29) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_ignored got done_after=%0d expected 29", c);
    end
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
    waitDone(c, b);
    tests_run++;
    if (c !== 33) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_latency got %0d expected 33", c);
    end
    repeat (40) tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_queued_op got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_mthi_mtlo();
    int c, b;
    logic [31:0] hold_hi;
    hold_hi = hi;
    mtlo = 1'b1; wdata = 32'h1234;
    tick();
    mtlo = 1'b0;
    tests_run++;
    if (lo !== 32'h1234 || hi !== hold_hi) begin
      tests_failed++;
      $display("[TB] FAIL mtlo got hi=%h lo=%h expected hi=%h lo=00001234", hi, lo, hold_hi);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    tests_run++;
    if (hi !== 32'hA5A5_5A5A || lo !== 32'hA5A5_5A5A) begin
      tests_failed++;
      $display("[TB] FAIL mthi_mtlo_both got hi=%h lo=%h expected a5a55a5a", hi, lo);
    end
    mthi = 1'b1; wdata = 32'h5555;
    applyStimulus(2'b10, 32'd100, 32'd7, {32'd2, 32'd14});
    mthi = 1'b0;
    tests_run++;
    if (hi !== 32'hA5A5_5A5A) begin
      tests_failed++;
      $display("[TB] FAIL mthi_with_start got hi=%h expected a5a55a5a", hi);
    end
    waitDone(c, b);
  endtask

  task automatic test_reset_mid();
    int c, b;
    applyStimulus(2'b00, 32'd12345, 32'd678, 64'd8369910);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_run got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(2'b01, 32'hFFFFF000, 32'd4096, 64'hFFFFFFFF_FF000000);
    waitDone(c, b);
    tests_run++;
    if (c !== 33 || b !== 33) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_latency got done_after=%0d busy_cycles=%0d expected 33/33", c, b);
    end
  endtask

  task automatic test_random();
    int c, b;
    logic [1:0]  o;
    logic [31:0] a, d;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom);
      a = $urandom;
      d = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      applyStimulus(o, a, d, model(o, a, d));
      waitDone(c, b);
      tests_run++;
      if (c !== 33) begin
        tests_failed++;
        $display("[TB] FAIL random_latency op=%0d got %0d expected 33", o, c);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_latency();
    test_signed();
    test_div_edge();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid();
    test_random();
    repeat (3) tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL missing_results got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
